// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling constants, baud divisor lookup
// and the parity helper used by the transmit and receive paths.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int DIV_W      = 14;
    localparam int BIT_CNT_W  = 4;
    localparam int IDX_W      = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int BAUD_RATE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

    // Precomputed round(50 MHz / (16 * baud)) for the common system clock.
    localparam logic [DIV_W-1:0] DIV_50MHZ [8] = '{
        14'd10417, 14'd2604, 14'd651, 14'd326, 14'd163, 14'd81, 14'd54, 14'd27
    };

    function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input logic [2:0] sel);
        int rate;
        rate = BAUD_RATE[sel];
        return DIV_W'((clk_hz + (rate * OVERSAMPLE) / 2) / (rate * OVERSAMPLE));
    endfunction

    function automatic logic parity_maker(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_controller_if.sv
// System-side byte interface and serial line of the UART transmitter.
interface uart_tx_controller_if;

    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic [2:0] baud_select;
    logic       TxD;
    logic       Tx_BUSY;

    modport master (
        output Tx_EN, Tx_WR, Tx_DATA, baud_select,
        input  TxD, Tx_BUSY
    );

    modport slave (
        input  Tx_EN, Tx_WR, Tx_DATA, baud_select,
        output TxD, Tx_BUSY
    );

endinterface

// File: rtl/uart_baud_gen.sv
// 16x oversampling baud divider; one-cycle sample_en each time the count wraps.
// Holding clear keeps the count at 0 so a frame starts phase-aligned.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [2:0] baud_select,
    output logic       sample_en
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_val;

    assign div_val   = (CLK_HZ == 50_000_000) ? DIV_50MHZ[baud_select] : baud_div(CLK_HZ, baud_select);
    assign sample_en = !clear && (cnt_q == (div_val - DIV_W'(1)));

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clear || sample_en) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: start, 8 data bits LSB first, even parity, stop.
// Outputs are registered from the next-state values so they change on the bit edge.
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_controller_if.slave   tx
);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   parity_q, parity_d;
    logic [2:0]             baud_q, baud_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BIT_CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   baud_clear;
    logic                   sample_en;
    logic                   bit_end;

    // Divider is cleared in IDLE and on the cycle enable drops, so aborts leave it at 0.
    assign baud_clear = (state_q == IDLE) || !tx.Tx_EN;
    assign bit_end    = sample_en && (bitcnt_q == BIT_CNT_W'(OVERSAMPLE - 1));

    uart_baud_gen #(.CLK_HZ(CLK_HZ)) u_baud_gen (
        .clk         (clk),
        .reset       (reset),
        .clear       (baud_clear),
        .baud_select (baud_q),
        .sample_en   (sample_en)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            baud_q   <= '0;
            idx_q    <= '0;
            bitcnt_q <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            bitcnt_q <= bitcnt_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        bitcnt_d = sample_en ? bitcnt_q + BIT_CNT_W'(1) : bitcnt_q;
        case (state_q)
            IDLE: begin
                if (tx.Tx_WR && tx.Tx_EN) begin
                    state_d  = START;
                    data_d   = tx.Tx_DATA;
                    baud_d   = tx.baud_select;
                    parity_d = parity_maker(tx.Tx_DATA);
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!tx.Tx_EN) begin
            state_d = IDLE;
        end
        if (state_d == IDLE) begin
            idx_d    = '0;
            bitcnt_d = '0;
        end
    end

    always_comb begin
        txd_d  = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            IDLE:    busy_d = 1'b0;
            START:   txd_d  = 1'b0;
            DATA:    txd_d  = data_q[idx_d];
            PARITY:  txd_d  = parity_q;
            STOP:    txd_d  = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    assign tx.TxD     = txd_q;
    assign tx.Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Scoreboard bench for uart_tx_controller: stimulus queues expected frames, a line
// monitor decodes each frame cycle by cycle and compares against the queue.
module tb_uart_tx_controller;

    typedef struct {
        logic [7:0] d;
        logic       par;
        int         div;
    } exp_t;

    logic clk;
    logic reset;
    logic mon_en;
    int   checks;
    int   failures;
    exp_t sb[$];

    uart_tx_controller_if bus ();

    uart_tx_controller dut (
        .clk   (clk),
        .reset (reset),
        .tx    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called on the first negedge of a start bit; walks all 11 bits cycle by cycle.
    task automatic check_frame();
        exp_t        e;
        logic [10:0] bits;
        int          bad;
        int          bad_busy;
        chk("frame_expected_in_scoreboard", (sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e        = sb.pop_front();
        bits     = {1'b1, e.par, e.d, 1'b0};
        bad_busy = 0;
        for (int k = 0; k < 11; k++) begin
            bad = 0;
            for (int c = 0; c < 16 * e.div; c++) begin
                if (bus.TxD !== bits[k]) bad++;
                if (bus.Tx_BUSY !== 1'b1) bad_busy++;
                @(negedge clk);
            end
            chk($sformatf("frame_%02h_bit%0d_bad_cycles", e.d, k), bad, 0);
        end
        chk($sformatf("frame_%02h_busy_low_cycles", e.d), bad_busy, 0);
        chk($sformatf("frame_%02h_busy_fall", e.d), bus.Tx_BUSY, 0);
        chk($sformatf("frame_%02h_idle_txd", e.d), bus.TxD, 1);
    endtask

    initial begin
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev === 1'b1 && bus.TxD === 1'b0) check_frame();
            prev = bus.TxD;
        end
    end

    task automatic issue(input logic [7:0] d, input logic [2:0] sel);
        bus.Tx_DATA     = d;
        bus.baud_select = sel;
        bus.Tx_WR       = 1'b1;
        @(negedge clk);
        bus.Tx_WR       = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic par, input int div);
        exp_t e;
        e.d   = d;
        e.par = par;
        e.div = div;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (bus.Tx_BUSY !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_within_bound", bus.Tx_BUSY, 0);
    endtask

    initial begin
        int bad;
        checks          = 0;
        failures        = 0;
        mon_en          = 1'b1;
        reset           = 1'b0;
        bus.Tx_EN       = 1'b1;
        bus.Tx_WR       = 1'b0;
        bus.Tx_DATA     = 8'h00;
        bus.baud_select = 3'd7;
        repeat (3) @(negedge clk);
        chk("reset_txd", bus.TxD, 1);
        chk("reset_busy", bus.Tx_BUSY, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("release_txd", bus.TxD, 1);
        chk("release_busy", bus.Tx_BUSY, 0);

        // Basic frames at 115200 (divisor 27): A5, 07, 00.
        expect_frame(8'hA5, 1'b0, 27);
        issue(8'hA5, 3'd7);
        wait_idle(6000);
        repeat (3) @(negedge clk);
        expect_frame(8'h07, 1'b1, 27);
        issue(8'h07, 3'd7);
        wait_idle(6000);
        repeat (3) @(negedge clk);
        expect_frame(8'h00, 1'b0, 27);
        issue(8'h00, 3'd7);
        wait_idle(6000);
        repeat (3) @(negedge clk);

        // Mid-frame write and rate change must not disturb the frame in flight.
        expect_frame(8'h81, 1'b0, 27);
        issue(8'h81, 3'd7);
        repeat (1000) @(negedge clk);
        issue(8'hFF, 3'd0);
        wait_idle(6000);
        bus.baud_select = 3'd7;
        repeat (20) @(negedge clk);
        chk("midframe_wr_not_queued_txd", bus.TxD, 1);
        chk("midframe_wr_not_queued_busy", bus.Tx_BUSY, 0);

        // Enable drop during data bit 3 truncates the frame.
        mon_en = 1'b0;
        issue(8'hC3, 3'd7);
        repeat (4 * 432 + 200) @(negedge clk);
        chk("abort_pre_txd_bit3", bus.TxD, 0);
        chk("abort_pre_busy", bus.Tx_BUSY, 1);
        bus.Tx_EN = 1'b0;
        @(negedge clk);
        chk("abort_txd", bus.TxD, 1);
        chk("abort_busy", bus.Tx_BUSY, 0);
        issue(8'hFF, 3'd7);
        bad = 0;
        repeat (100) begin
            if (bus.TxD !== 1'b1 || bus.Tx_BUSY !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("wr_while_disabled_ignored_cycles", bad, 0);
        bus.Tx_EN = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Asynchronous reset during the parity bit, then a clean frame at 57600.
        mon_en = 1'b0;
        issue(8'h96, 3'd7);
        repeat (9 * 432 + 100) @(negedge clk);
        chk("reset_pre_parity_txd", bus.TxD, 0);
        chk("reset_pre_busy", bus.Tx_BUSY, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_txd", bus.TxD, 1);
        chk("async_reset_busy", bus.Tx_BUSY, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        expect_frame(8'h3C, 1'b0, 54);
        issue(8'h3C, 3'd6);
        wait_idle(11000);
        repeat (3) @(negedge clk);

        // Back-to-back: second write on the first BUSY-low cycle.
        expect_frame(8'h55, 1'b0, 27);
        issue(8'h55, 3'd7);
        wait_idle(6000);
        expect_frame(8'hAA, 1'b0, 27);
        issue(8'hAA, 3'd7);
        chk("b2b_start_txd", bus.TxD, 0);
        chk("b2b_start_busy", bus.Tx_BUSY, 1);
        // Strobe sampled on the edge where BUSY falls must be dropped.
        repeat (176 * 27 - 1) @(negedge clk);
        issue(8'h0F, 3'd7);
        chk("fall_edge_busy", bus.Tx_BUSY, 0);
        @(negedge clk);
        chk("fall_edge_wr_dropped_txd", bus.TxD, 1);
        chk("fall_edge_wr_dropped_busy", bus.Tx_BUSY, 0);
        repeat (50) @(negedge clk);
        chk("fall_edge_still_idle_busy", bus.Tx_BUSY, 0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
